// File: rtl/lcd_ctrl_if.sv
// Register-word and LCD pin bundle between the load/store unit and the LCD write engine.
interface lcd_ctrl_if;
  logic [31:0] lcd_word_i;
  logic [7:0]  lcd_data_o;
  logic        lcd_rs_o;
  logic        lcd_rw_o;
  logic        lcd_en_o;
  logic        lcd_on_o;
  logic        lcd_blon_o;
  logic [31:0] status_o;

  // Engine side: consumes the register word, drives pins and status.
  modport slave (
    input  lcd_word_i,
    output lcd_data_o,
    output lcd_rs_o,
    output lcd_rw_o,
    output lcd_en_o,
    output lcd_on_o,
    output lcd_blon_o,
    output status_o
  );

  // Software/LSU side: supplies the register word, observes pins and status.
  modport master (
    output lcd_word_i,
    input  lcd_data_o,
    input  lcd_rs_o,
    input  lcd_rw_o,
    input  lcd_en_o,
    input  lcd_on_o,
    input  lcd_blon_o,
    input  status_o
  );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 character-LCD write engine: one timed bus write per REQ toggle,
// with power-up wait, setup/enable/hold timing and per-command execution wait.
module lcd_ctrl #(
  parameter int unsigned T_POWERUP   = 750000,
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_EN_HIGH   = 12,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 82000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  lcd_ctrl_if.slave  bus
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_EN_HIGH, T_HOLD)),
                                       max2(T_EXEC, T_EXEC_LONG));
  localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

  localparam int unsigned BIT_ON   = 31;
  localparam int unsigned BIT_BLON = 30;
  localparam int unsigned BIT_REQ  = 29;
  localparam int unsigned BIT_RS   = 8;

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_IDLE    = 3'd1,
    S_SETUP   = 3'd2,
    S_PULSE   = 3'd3,
    S_HOLD    = 3'd4,
    S_EXEC    = 3'd5
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_data;
  logic             r_rs;
  logic             r_en;
  logic             r_busy;
  logic             r_ack;
  logic             r_init_done;
  logic             r_on;
  logic             r_blon;

  logic             w_pending;
  logic             w_cnt_last;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_long_cmd;
  logic [CNT_W-1:0] w_exec_load;
  logic             w_unused_bits;

  // A request is outstanding whenever the software toggle differs from our acknowledge.
  assign w_pending  = bus.lcd_word_i[BIT_REQ] ^ r_ack;
  assign w_cnt_last = (r_cnt == CNT_W'(1));
  assign w_cnt_dec  = r_cnt - CNT_W'(1);

  // Clear (0x01) and return-home (0x02/0x03) are the only slow instructions.
  assign w_long_cmd  = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) || (r_data == 8'h03));
  assign w_exec_load = w_long_cmd ? CNT_W'(T_EXEC_LONG) : CNT_W'(T_EXEC);

  // Bits of the register word this engine does not interpret.
  assign w_unused_bits = ^{bus.lcd_word_i[28:9]};

  // Write-cycle sequencer; every timed state loads its count on entry and leaves when it reaches 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_POWERUP;
      r_cnt       <= CNT_W'(T_POWERUP);
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_en        <= 1'b0;
      r_busy      <= 1'b1;
      r_ack       <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        S_POWERUP: begin
          if (w_cnt_last) begin
            r_state     <= S_IDLE;
            r_init_done <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end

        S_IDLE: begin
          if (w_pending) begin
            r_state <= S_SETUP;
            r_cnt   <= CNT_W'(T_SETUP);
            r_data  <= bus.lcd_word_i[7:0];
            r_rs    <= bus.lcd_word_i[BIT_RS];
            r_busy  <= 1'b1;
          end
        end

        S_SETUP: begin
          if (w_cnt_last) begin
            r_state <= S_PULSE;
            r_cnt   <= CNT_W'(T_EN_HIGH);
            r_en    <= 1'b1;
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end

        S_PULSE: begin
          if (w_cnt_last) begin
            r_state <= S_HOLD;
            r_cnt   <= CNT_W'(T_HOLD);
            r_en    <= 1'b0;
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end

        S_HOLD: begin
          if (w_cnt_last) begin
            r_state <= S_EXEC;
            r_cnt   <= w_exec_load;
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end

        S_EXEC: begin
          if (w_cnt_last) begin
            r_state <= S_IDLE;
            r_ack   <= ~r_ack;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end

        default: begin
          // Unreachable encodings fall back to a fresh power-up wait.
          r_state     <= S_POWERUP;
          r_cnt       <= CNT_W'(T_POWERUP);
          r_en        <= 1'b0;
          r_busy      <= 1'b1;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  // Power and backlight follow the register word with one register stage, independent of the sequencer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_on   <= 1'b0;
      r_blon <= 1'b0;
    end else begin
      r_on   <= bus.lcd_word_i[BIT_ON];
      r_blon <= bus.lcd_word_i[BIT_BLON];
    end
  end

  assign bus.lcd_data_o = r_data;
  assign bus.lcd_rs_o   = r_rs;
  assign bus.lcd_rw_o   = 1'b0;
  assign bus.lcd_en_o   = r_en;
  assign bus.lcd_on_o   = r_on;
  assign bus.lcd_blon_o = r_blon;
  assign bus.status_o   = {29'd0, r_init_done, r_ack, r_busy};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: stimulus queues every expected pin/status change
// with the cycle it must appear on; the monitor pops one entry per observed change.
module tb_lcd_ctrl;

  logic clk;
  logic rst;
  int   cyc;
  logic done;

  lcd_ctrl_if bus ();

  lcd_ctrl #(
    .T_POWERUP  (10),
    .T_SETUP    (2),
    .T_EN_HIGH  (3),
    .T_HOLD     (2),
    .T_EXEC     (5),
    .T_EXEC_LONG(20)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct packed {
    int          cyc;
    logic [44:0] snap;
  } ev_t;

  ev_t exp_q[$];
  int  checks;
  int  errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter; outputs sampled at negedge carry the count of the edge that produced them.
  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [44:0] mk(input logic [2:0] st, input logic [7:0] d, input logic rs,
                                     input logic en, input logic on, input logic bl);
    return {29'd0, st, d, rs, 1'b0, en, on, bl};
  endfunction

  task automatic push(input int c, input logic [44:0] s);
    ev_t e;
    e.cyc  = c;
    e.snap = s;
    exp_q.push_back(e);
  endtask

  task automatic goto_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  // Stimulus: drive at negedge, queue the hand-computed responses.
  initial begin
    done           = 1'b0;
    rst            = 1'b1;
    bus.lcd_word_i = 32'h0;
    push(1,  mk(3'h1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    push(12, mk(3'h4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    goto_cyc(2);
    rst = 1'b0;

    // Data write, short exec.
    goto_cyc(14);
    bus.lcd_word_i = 32'h2000_0141;
    push(15, mk(3'h5, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0));
    push(17, mk(3'h5, 8'h41, 1'b1, 1'b1, 1'b0, 1'b0));
    push(20, mk(3'h5, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0));
    push(27, mk(3'h6, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0));

    // Data change during PULSE must not reach the pins.
    goto_cyc(18);
    bus.lcd_word_i = 32'h2000_01FF;

    // Clear command, long exec.
    goto_cyc(28);
    bus.lcd_word_i = 32'h0000_0001;
    push(29, mk(3'h7, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
    push(31, mk(3'h7, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0));
    push(34, mk(3'h7, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
    push(56, mk(3'h4, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0));

    // ON/BLON only, no request.
    goto_cyc(58);
    bus.lcd_word_i = 32'hC000_0000;
    push(59, mk(3'h4, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1));

    // Request interrupted by reset in PULSE, then served after POWERUP.
    goto_cyc(61);
    bus.lcd_word_i = 32'hE000_0155;
    push(62, mk(3'h5, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1));
    push(64, mk(3'h5, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1));
    goto_cyc(65);
    rst = 1'b1;
    push(66, mk(3'h1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    goto_cyc(66);
    rst = 1'b0;
    push(67, mk(3'h1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1));
    push(76, mk(3'h4, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1));
    push(77, mk(3'h5, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1));
    push(79, mk(3'h5, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1));
    push(82, mk(3'h5, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1));
    push(89, mk(3'h6, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1));

    // RS=1 with 0x01 is data, so short exec.
    goto_cyc(91);
    bus.lcd_word_i = 32'hC000_0101;
    push(92,  mk(3'h7, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1));
    push(94,  mk(3'h7, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1));
    push(97,  mk(3'h7, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1));
    push(104, mk(3'h4, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1));

    // Home (0x03) is long.
    goto_cyc(106);
    bus.lcd_word_i = 32'hE000_0003;
    push(107, mk(3'h5, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1));
    push(109, mk(3'h5, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1));
    push(112, mk(3'h5, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1));
    push(134, mk(3'h6, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1));

    // 0x04 is just above the long range.
    goto_cyc(136);
    bus.lcd_word_i = 32'hC000_0004;
    push(137, mk(3'h7, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1));
    push(139, mk(3'h7, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1));
    push(142, mk(3'h7, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1));
    push(149, mk(3'h4, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1));

    goto_cyc(155);
    done = 1'b1;
  end

  // Monitor: every change of the observed outputs consumes one queued expectation.
  logic [44:0] prev;
  logic [44:0] cur;
  ev_t         e;
  initial begin
    checks = 0;
    errors = 0;
    prev   = 'x;
  end

  always @(negedge clk) begin
    cur = {bus.status_o, bus.lcd_data_o, bus.lcd_rs_o, bus.lcd_rw_o,
           bus.lcd_en_o, bus.lcd_on_o, bus.lcd_blon_o};
    if (cur !== prev) begin
      prev   = cur;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_change: cyc=%0d got=%h (no change expected)", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e.snap || cyc != e.cyc) begin
          errors = errors + 1;
          $display("FAIL event@%0d: got cyc=%0d snap=%h, expected cyc=%0d snap=%h",
                   e.cyc, cyc, cur, e.cyc, e.snap);
        end
      end
    end
    if (done || cyc > 2000) begin
      checks = checks + 1;
      if (!done || exp_q.size() != 0) begin
        errors = errors + 1;
        $display("FAIL missing_events: got %0d outstanding (done=%0d), expected 0",
                 exp_q.size(), done);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

endmodule
